// File: rtl/paddle_if.sv
// Player-input and game-state bundle shared by the encoder/button front ends,
// the paddle controller and the ball/render logic that follow its outputs.
interface paddle_if;
    logic       p1_up;
    logic       p1_down;
    logic       p2_up;
    logic       p2_down;
    logic       p1_btn;
    logic       p2_btn;
    logic       point_scored;
    logic       scorer;
    logic [9:0] p1_y;
    logic [9:0] p2_y;
    logic [1:0] mode;
    logic       serve_player;
    logic       start_serve;

    modport master (
        output p1_up, p1_down, p2_up, p2_down, p1_btn, p2_btn, point_scored, scorer,
        input  p1_y, p2_y, mode, serve_player, start_serve
    );

    modport slave (
        input  p1_up, p1_down, p2_up, p2_down, p1_btn, p2_btn, point_scored, scorer,
        output p1_y, p2_y, mode, serve_player, start_serve
    );
endinterface

// File: rtl/paddle_controller.sv
// Pong game-input sequencer: paddle positions with clamping, button debounce
// and the game-mode FSM.
//
//   state | meaning
//   IDLE  | waiting for any press to begin a game
//   SERVE | ball held; serve_player's press launches it
//   PLAY  | rally in progress; score -> SERVE, press -> PAUSE
//   PAUSE | frozen; any press resumes PLAY without a new serve
module paddle_controller #(
    parameter int SCREEN_H   = 480,
    parameter int PADDLE_H   = 64,
    parameter int STEP       = 8,
    parameter int BTN_STABLE = 250000
) (
    input  logic     clk,
    input  logic     rst,
    paddle_if.slave  bus
);
    localparam logic [9:0] Y_MAX  = 10'(SCREEN_H - PADDLE_H);
    localparam logic [9:0] Y_MID  = 10'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [9:0] STEP_Y = 10'(STEP);
    localparam int         CNT_W  = $clog2(BTN_STABLE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BTN_STABLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2,
        PAUSE = 2'd3
    } mode_t;

    mode_t            state;
    mode_t            state_next;
    logic             serve_player_q;
    logic             serve_player_next;
    logic             start_serve_q;
    logic             start_serve_next;
    logic [9:0]       p1_y_q;
    logic [9:0]       p2_y_q;
    logic [1:0]       raw;
    logic [1:0]       accepted;
    logic [1:0]       press;
    logic [CNT_W-1:0] cnt [2];
    logic             any_press;
    logic             paddles_live;
    logic             recentre;

    assign raw = {bus.p2_btn, bus.p1_btn};

    // Comparison happens before the add/subtract so the 10-bit result never wraps.
    function automatic logic [9:0] move_y(input logic [9:0] y, input logic up, input logic down);
        logic [9:0] r;
        r = y;
        if (up && !down) begin
            r = (y < STEP_Y) ? 10'd0 : y - STEP_Y;
        end else if (down && !up) begin
            r = (y > Y_MAX - STEP_Y) ? Y_MAX : y + STEP_Y;
        end
        return r;
    endfunction

    // Debounce both buttons; the counter hitting its last value on a mismatch
    // means the new level has held for BTN_STABLE cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
            accepted <= '0;
            press    <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (raw[i] == accepted[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    accepted[i] <= raw[i];
                    cnt[i]      <= '0;
                    press[i]    <= raw[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Mode FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            serve_player_q <= 1'b0;
            start_serve_q  <= 1'b0;
        end else begin
            state          <= state_next;
            serve_player_q <= serve_player_next;
            start_serve_q  <= start_serve_next;
        end
    end

    assign any_press = |press;

    // Next mode; a score in PLAY wins over a press in the same cycle.
    always_comb begin
        state_next        = state;
        serve_player_next = serve_player_q;
        start_serve_next  = 1'b0;
        case (state)
            IDLE: begin
                if (any_press) begin
                    state_next        = SERVE;
                    serve_player_next = 1'b0;
                end
            end
            SERVE: begin
                if (press[serve_player_q]) begin
                    state_next       = PLAY;
                    start_serve_next = 1'b1;
                end
            end
            PLAY: begin
                if (bus.point_scored) begin
                    state_next        = SERVE;
                    serve_player_next = ~bus.scorer;
                end else if (any_press) begin
                    state_next = PAUSE;
                end
            end
            PAUSE: begin
                if (any_press) begin
                    state_next = PLAY;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign paddles_live = (state == SERVE) || (state == PLAY);
    assign recentre     = (state == IDLE) && (state_next == SERVE);

    // Paddle positions: centred on a new game, moved only while the ball is live.
    always_ff @(posedge clk) begin
        if (rst || recentre) begin
            p1_y_q <= Y_MID;
            p2_y_q <= Y_MID;
        end else if (paddles_live) begin
            p1_y_q <= move_y(p1_y_q, bus.p1_up, bus.p1_down);
            p2_y_q <= move_y(p2_y_q, bus.p2_up, bus.p2_down);
        end
    end

    assign bus.p1_y         = p1_y_q;
    assign bus.p2_y         = p2_y_q;
    assign bus.mode         = state;
    assign bus.serve_player = serve_player_q;
    assign bus.start_serve  = start_serve_q;
endmodule

// File: tb/tb_paddle_controller.sv
// Bench for paddle_controller: directed scenarios plus random play, all checked
// cycle by cycle against a behavioural model of the game rules.
module tb_paddle_controller;
    localparam int STAB = 4;
    localparam int STEP = 8;
    localparam int YMAX = 416;
    localparam int YMID = 208;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    paddle_if bus();

    paddle_controller #(
        .SCREEN_H  (480),
        .PADDLE_H  (64),
        .STEP      (STEP),
        .BTN_STABLE(STAB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int ss_count = 0;

    int m_y[2];
    int m_mode;
    int m_sp;
    int m_ss;
    int m_cnt[2];
    int m_acc[2];
    int m_press[2];

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int moved(input int y, input int up, input int dn);
        if (up != 0 && dn == 0) return (y - STEP < 0) ? 0 : y - STEP;
        if (dn != 0 && up == 0) return (y + STEP > YMAX) ? YMAX : y + STEP;
        return y;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_sp   = 0;
        m_ss   = 0;
        for (int i = 0; i < 2; i++) begin
            m_y[i]     = YMID;
            m_cnt[i]   = 0;
            m_acc[i]   = 0;
            m_press[i] = 0;
        end
    endtask

    // Advances the model by one clock using the inputs that were sampled at the edge.
    task automatic model_step();
        int raw[2];
        int up[2];
        int dn[2];
        int seen[2];
        int any;
        int old_mode;
        raw[0] = int'(bus.p1_btn);  raw[1] = int'(bus.p2_btn);
        up[0]  = int'(bus.p1_up);   up[1]  = int'(bus.p2_up);
        dn[0]  = int'(bus.p1_down); dn[1]  = int'(bus.p2_down);
        if (rst) begin
            model_reset();
            return;
        end
        seen[0]  = m_press[0];
        seen[1]  = m_press[1];
        any      = seen[0] | seen[1];
        old_mode = m_mode;
        m_ss     = 0;
        case (old_mode)
            0: if (any != 0) begin
                m_mode = 1;
                m_sp   = 0;
                m_y[0] = YMID;
                m_y[1] = YMID;
            end
            1: if (seen[m_sp] != 0) begin
                m_mode = 2;
                m_ss   = 1;
            end
            2: if (bus.point_scored) begin
                m_mode = 1;
                m_sp   = bus.scorer ? 0 : 1;
            end else if (any != 0) begin
                m_mode = 3;
            end
            default: if (any != 0) m_mode = 2;
        endcase
        if (old_mode == 1 || old_mode == 2) begin
            for (int i = 0; i < 2; i++) m_y[i] = moved(m_y[i], up[i], dn[i]);
        end
        for (int i = 0; i < 2; i++) begin
            m_press[i] = 0;
            if (raw[i] == m_acc[i]) begin
                m_cnt[i] = 0;
            end else begin
                m_cnt[i]++;
                if (m_cnt[i] == STAB) begin
                    m_acc[i]   = raw[i];
                    m_cnt[i]   = 0;
                    m_press[i] = raw[i];
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        chk("p1_y", int'(bus.p1_y), m_y[0]);
        chk("p2_y", int'(bus.p2_y), m_y[1]);
        chk("mode", int'(bus.mode), m_mode);
        chk("serve_player", int'(bus.serve_player), m_sp);
        chk("start_serve", int'(bus.start_serve), m_ss);
        if (bus.start_serve) ss_count++;
        bus.p1_up        = 1'b0;
        bus.p1_down      = 1'b0;
        bus.p2_up        = 1'b0;
        bus.p2_down      = 1'b0;
        bus.point_scored = 1'b0;
    endtask

    task automatic press_btn(input int player);
        if (player == 0) bus.p1_btn = 1'b1; else bus.p2_btn = 1'b1;
        repeat (STAB + 2) cycle();
        if (player == 0) bus.p1_btn = 1'b0; else bus.p2_btn = 1'b0;
        repeat (STAB + 2) cycle();
    endtask

    initial begin
        int first;
        rst              = 1'b1;
        bus.p1_up        = 1'b0;
        bus.p1_down      = 1'b0;
        bus.p2_up        = 1'b0;
        bus.p2_down      = 1'b0;
        bus.p1_btn       = 1'b0;
        bus.p2_btn       = 1'b0;
        bus.point_scored = 1'b0;
        bus.scorer       = 1'b0;
        model_reset();

        repeat (2) cycle();
        rst = 1'b0;
        chk("reset_mode", int'(bus.mode), 0);
        chk("reset_y", int'(bus.p1_y), YMID);

        // Encoder pulses in IDLE are dropped.
        repeat (3) begin
            bus.p1_up = 1'b1;
            cycle();
        end
        chk("idle_p1_y", int'(bus.p1_y), YMID);
        chk("idle_mode", int'(bus.mode), 0);

        // Glitchy button: only the stable high run is accepted.
        bus.p1_btn = 1'b1;
        repeat (3) cycle();
        bus.p1_btn = 1'b0;
        cycle();
        bus.p1_btn = 1'b1;
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (first == 0 && bus.mode == 2'd1) first = k;
        end
        chk("debounce_latency", first, STAB + 1);
        bus.p1_btn = 1'b0;
        repeat (STAB + 2) cycle();
        chk("debounce_mode", int'(bus.mode), 1);

        // Clamping at top and bottom.
        for (int i = 1; i <= 30; i++) begin
            bus.p2_up = 1'b1;
            cycle();
            if (i == 25) chk("clamp_25", int'(bus.p2_y), 8);
            if (i == 26) chk("clamp_26", int'(bus.p2_y), 0);
        end
        chk("clamp_top", int'(bus.p2_y), 0);
        repeat (60) begin
            bus.p2_down = 1'b1;
            cycle();
        end
        chk("clamp_bottom", int'(bus.p2_y), YMAX);
        bus.p1_up   = 1'b1;
        bus.p1_down = 1'b1;
        cycle();
        chk("both_dirs", int'(bus.p1_y), YMID);

        // Serve handshake: only the server's press launches.
        ss_count = 0;
        press_btn(1);
        chk("serve_other", int'(bus.mode), 1);
        chk("serve_other_ss", ss_count, 0);
        press_btn(0);
        chk("serve_play", int'(bus.mode), 2);
        chk("serve_ss_once", ss_count, 1);

        // Score and press land on the same edge; score wins.
        bus.p2_btn = 1'b1;
        repeat (STAB) cycle();
        bus.point_scored = 1'b1;
        bus.scorer       = 1'b0;
        cycle();
        chk("prio_mode", int'(bus.mode), 1);
        chk("prio_sp", int'(bus.serve_player), 1);
        cycle();
        bus.p2_btn = 1'b0;
        repeat (STAB + 2) cycle();
        chk("prio_no_pause", int'(bus.mode), 1);

        // Pause freezes paddles and ignores scoring.
        press_btn(1);
        chk("pause_play", int'(bus.mode), 2);
        repeat (2) begin
            bus.p1_down = 1'b1;
            cycle();
        end
        bus.p2_up = 1'b1;
        cycle();
        press_btn(0);
        chk("pause_enter", int'(bus.mode), 3);
        bus.p1_up        = 1'b1;
        bus.p2_down      = 1'b1;
        bus.point_scored = 1'b1;
        cycle();
        bus.p1_up = 1'b1;
        cycle();
        chk("pause_mode", int'(bus.mode), 3);
        chk("pause_p1_y", int'(bus.p1_y), YMID + 16);
        chk("pause_p2_y", int'(bus.p2_y), YMAX - 8);
        press_btn(1);
        chk("resume_mode", int'(bus.mode), 2);
        chk("resume_ss", ss_count, 2);
        chk("resume_p1_y", int'(bus.p1_y), YMID + 16);

        // Random play against the model.
        for (int n = 0; n < 4000; n++) begin
            rst              = ($urandom_range(0, 699) == 0);
            bus.p1_up        = ($urandom_range(0, 2) == 0);
            bus.p1_down      = ($urandom_range(0, 2) == 0);
            bus.p2_up        = ($urandom_range(0, 2) == 0);
            bus.p2_down      = ($urandom_range(0, 2) == 0);
            bus.point_scored = ($urandom_range(0, 19) == 0);
            bus.scorer       = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 9) == 0) bus.p1_btn = ~bus.p1_btn;
            if ($urandom_range(0, 9) == 0) bus.p2_btn = ~bus.p2_btn;
            cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/paddle_controller.md
# paddle_controller

Game-input sequencer for Pong. It consumes the one-cycle `up`/`down` pulses and raw button levels from both players' rotary-encoder front ends, and maintains both paddles' vertical positions with clamping. It debounces the two push buttons and runs the top-level game-mode state machine (idle / serve / play / pause) that the ball and render logic follow.

## Interface
- `SCREEN_H`, 480: playfield height in pixels.
- `PADDLE_H`, 64: paddle height in pixels.
- `STEP`, 8: pixels moved per encoder pulse; must be ≥1.
- `BTN_STABLE`, 250000: consecutive cycles a button level must hold before it is accepted; must be ≥2.
- `clk`  in  1  system clock, the single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `p1_up`, `p1_down`  in  1 each  player-1 encoder step pulses, one cycle wide.
- `p2_up`, `p2_down`  in  1 each  player-2 encoder step pulses, one cycle wide.
- `p1_btn`, `p2_btn`  in  1 each  button levels, already synchronised; 1 = pressed.
- `point_scored`  in  1  one-cycle pulse from the ball logic.
- `scorer`  in  1  qualifies `point_scored`: 0 = player 1 scored, 1 = player 2 scored.
- `p1_y`, `p2_y`  out  10 each  paddle top edge in pixels, registered.
- `mode`  out  2  game mode: 0 IDLE, 1 SERVE, 2 PLAY, 3 PAUSE.
- `serve_player`  out  1  player who serves next: 0 = p1, 1 = p2.
- `start_serve`  out  1  one-cycle pulse that launches the ball.

## Operation
- **Reset values:** `mode`=IDLE, `serve_player`=0, `start_serve`=0, `p1_y`=`p2_y`=(SCREEN_H−PADDLE_H)/2 (208 with defaults), debounce counters 0, accepted button levels 0.
- **Debounce, one per player:**
  - The counter increments while the raw level differs from the accepted level, and clears to 0 when they match.
  - When the counter reaches BTN_STABLE, the accepted level takes the raw level and the counter clears.
  - A 0→1 change of the accepted level produces an internal `press` pulse, one cycle wide.
  - Releases produce no event. A held button yields exactly one press.
- **Paddle update, per player, independent:**
  - Enabled only in SERVE and PLAY. Pulses arriving in IDLE or PAUSE are dropped, not queued.
  - up=1, down=0: y ← (y < STEP) ? 0 : y−STEP.
  - down=1, up=0: y ← (y > YMAX−STEP) ? YMAX : y+STEP, where YMAX = SCREEN_H−PADDLE_H (416).
  - up and down both high in the same cycle: y unchanged.
  - The comparison is done before the add/subtract, so no underflow or overflow wrap is possible. Arithmetic is 10-bit unsigned.
- **Mode FSM:**
  - IDLE: press from either player → SERVE with `serve_player`=0. Paddles are re-centred on this transition.
  - SERVE: press by the `serve_player` player → PLAY and `start_serve`=1 for one cycle. A press by the other player is ignored.
  - PLAY:
    - `point_scored` → SERVE with `serve_player` = ~`scorer` (the conceding player serves).
    - Otherwise, press by either player → PAUSE.
  - PAUSE: press by either player → PLAY. `point_scored` is ignored. `start_serve` is not re-issued.
- **Simultaneous events:**
  - In PLAY, `point_scored` takes priority over a press in the same cycle; that press is discarded.
  - Presses from both players in the same cycle cause a single transition.
  - In SERVE, a simultaneous press from both players is accepted because the server is among them.
- **Reset mid-operation:** `rst` high at any edge overrides all inputs and restores the reset values at that edge. A press in progress restarts from a zero count.

## Timing
- Paddle: an encoder pulse sampled at edge N gives the updated `p*_y` visible after edge N. Latency is 1 cycle and back-to-back pulses are applied every cycle.
- Button: raw level high from before edge 1 and held gives an accepted level after edge BTN_STABLE, a `press` pulse after that same edge, and a `mode` change after edge BTN_STABLE+1.
- `start_serve` is asserted in the same cycle that `mode` first reads PLAY from SERVE.
- `point_scored` sampled at edge N gives `mode`=SERVE and the new `serve_player` after edge N.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset / idle:** apply `rst` for 2 cycles, then pulse `p1_up` ×3 in IDLE → `p1_y`=208, `mode`=0, `start_serve` never asserted.
- **Debounce:** with BTN_STABLE=4, a glitchy `p1_btn` (high 3 cycles, low 1, then held high 10 cycles) → exactly one transition IDLE→SERVE, occurring 5 cycles after the start of the stable high period.
- **Clamping:** in SERVE, 30 `p2_up` pulses → `p2_y` 208→0 after 26 pulses and stays 0. Then 60 `p2_down` pulses → `p2_y` saturates at 416. One cycle with `p1_up`=`p1_down`=1 → `p1_y` unchanged.
- **Serve handshake:** in SERVE with `serve_player`=0, a p2 press → no change; a p1 press → PLAY with a single-cycle `start_serve`.
- **Scoring vs pause priority:** in PLAY, `point_scored`=1 with `scorer`=0 in the same cycle as the debounced p2 press → `mode`=SERVE, `serve_player`=1, and no PAUSE.
- **Pause:** in PLAY, a press → PAUSE. Encoder pulses and `point_scored` in PAUSE → no change. A second press → PLAY with `start_serve`=0 and paddles at their pre-pause values.
